// File: rtl/upscale_feeder.sv
// upscale_feeder: stream source for the upscaler's replicated-pixel input.
// Source rows are captured into a two-bank line buffer. Each buffered row is
// re-emitted SCALE times with every pixel repeated SCALE times, and one idle
// (gap) beat follows every replicated line.
// Optional feature macro: UPSCALE_FEED_EOL_EN adds an `eol` output that marks
// the final beat of each replicated line.
module upscale_feeder #(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] pixel_out,
  output logic             output_valid,
  output logic             frame_done
`ifdef UPSCALE_FEED_EOL_EN
  ,
  output logic             eol
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int HW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(SCALE - 1);
  localparam logic [HW-1:0] ROW_LAST = HW'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Line buffer storage; contents are only meaningful while the bank is full.
  logic [PIX_W-1:0] mem_q [2][IMG_W];

  // Write side
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          wr_bank_q;
  logic          wr_bank_d;
  logic [CW-1:0] wcol_q;
  logic [CW-1:0] wcol_d;
  logic          accept_s;
  logic          rd_free_s;

  // Read side
  state_t        state_q;
  logic          rd_bank_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] rep_q;
  logic [RW-1:0] line_q;
  logic [HW-1:0] row_q;

  // Registered outputs
  logic [PIX_W-1:0] pixel_q;
  logic             valid_q;
  logic             frame_done_q;
`ifdef UPSCALE_FEED_EOL_EN
  logic             eol_q;
`endif

  assign s_ready   = ~full_q[wr_bank_q];
  assign accept_s  = s_valid & s_ready;
  // A bank is released on the gap beat that follows its last replicated line.
  assign rd_free_s = (state_q == ST_GAP) && (line_q == REP_LAST);

  // Next-state for the write column, write bank and the bank-full flags.
  always_comb begin
    wcol_d    = wcol_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (accept_s) begin
      if (wcol_q == COL_LAST) begin
        wcol_d            = {CW{1'b0}};
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wcol_d = wcol_q + CW'(1);
      end
    end else begin
      wcol_d = wcol_q;
    end
    // Set and clear never target the same bank: writes need an empty bank,
    // the release needs a full one.
    if (rd_free_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end
  end

  // Write-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_q    <= {CW{1'b0}};
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wcol_q    <= wcol_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  // Capture accepted source pixels into the current write bank.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_bank_q][wcol_q] <= s_pixel;
    end
  end

  // Read FSM: replicate the buffered row and drive the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_bank_q    <= 1'b0;
      col_q        <= {CW{1'b0}};
      rep_q        <= {RW{1'b0}};
      line_q       <= {RW{1'b0}};
      row_q        <= {HW{1'b0}};
      pixel_q      <= {PIX_W{1'b0}};
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UPSCALE_FEED_EOL_EN
      eol_q        <= 1'b0;
`endif
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UPSCALE_FEED_EOL_EN
      eol_q        <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q <= ST_EMIT;
            col_q   <= {CW{1'b0}};
            rep_q   <= {RW{1'b0}};
            line_q  <= {RW{1'b0}};
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          pixel_q <= mem_q[rd_bank_q][col_q];
          valid_q <= 1'b1;
`ifdef UPSCALE_FEED_EOL_EN
          eol_q   <= (col_q == COL_LAST) && (rep_q == REP_LAST);
`endif
          if (rep_q == REP_LAST) begin
            rep_q <= {RW{1'b0}};
            if (col_q == COL_LAST) begin
              col_q   <= {CW{1'b0}};
              state_q <= ST_GAP;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end else begin
            rep_q <= rep_q + RW'(1);
          end
        end
        ST_GAP: begin
          if (line_q != REP_LAST) begin
            line_q  <= line_q + RW'(1);
            state_q <= ST_EMIT;
          end else begin
            line_q    <= {RW{1'b0}};
            rd_bank_q <= ~rd_bank_q;
            if (row_q == ROW_LAST) begin
              row_q        <= {HW{1'b0}};
              frame_done_q <= 1'b1;
            end else begin
              row_q <= row_q + HW'(1);
            end
            // Chain straight into the next row when it is already buffered.
            if (full_q[~rd_bank_q]) begin
              state_q <= ST_EMIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pixel_out    = pixel_q;
  assign output_valid = valid_q;
  assign frame_done   = frame_done_q;
`ifdef UPSCALE_FEED_EOL_EN
  assign eol          = eol_q;
`endif

endmodule
